// File: rtl/mcu_input_pkg.sv
// mcu_input_pkg: read addresses, debounce states and status byte layout for the MCU input port
package mcu_input_pkg;

    localparam logic [7:0] ADDR_DATA     = 8'h00;
    localparam logic [7:0] ADDR_STATUS   = 8'h01;
    localparam logic [7:0] ADDR_SWITCHES = 8'h02;

    localparam int ST_OVERFLOW  = 6;
    localparam int ST_FULL      = 5;
    localparam int ST_COUNT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    function automatic logic [7:0] pack_status(input logic ovf, input logic is_full, input logic [4:0] cnt);
        logic [7:0] s;
        s = 8'h00;
        s[ST_OVERFLOW] = ovf;
        s[ST_FULL] = is_full;
        s[ST_COUNT_LSB +: 5] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// input_debounce: two-flop synchroniser and press/release debounce FSM for one bouncy pin
module input_debounce
    import mcu_input_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic capture
);

    logic [1:0] sync;
    db_state_t state, state_next;
    logic [15:0] cnt, cnt_next;
    logic done;

    assign level = sync[1];
    assign done = cnt == DEBOUNCE_CYCLES - 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= 2'b00;
            state <= IDLE;
            cnt <= 16'd0;
        end else begin
            sync <= {sync[0], din};
            state <= state_next;
            cnt <= cnt_next;
        end
    end

    // the counter only runs inside the two wait states and restarts everywhere else
    always_comb begin
        state_next = state;
        cnt_next = 16'd0;
        capture = 1'b0;
        case (state)
            IDLE:         state_next = level ? PRESS_WAIT : IDLE;
            PRESS_WAIT: begin
                state_next = !level ? IDLE : done ? PRESSED : PRESS_WAIT;
                cnt_next = (level && !done) ? cnt + 16'd1 : 16'd0;
                capture = level && done;
            end
            PRESSED:      state_next = level ? PRESSED : RELEASE_WAIT;
            RELEASE_WAIT: begin
                state_next = level ? PRESSED : done ? IDLE : RELEASE_WAIT;
                cnt_next = (!level && !done) ? cnt + 16'd1 : 16'd0;
            end
            default:      state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/mcu_input_port.sv
// mcu_input_port: captures the switch byte on each debounced press into a FIFO read by the MCU
module mcu_input_port
    import mcu_input_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] fpga_in,
    input  logic       input_read_enable,
    input  logic [7:0] input_data_address,
    output logic [7:0] input_data_out,
    output logic       input_data_valid,
    output logic       press_pending
);

    localparam int         PW    = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

    logic [7:0] sw_meta, sw;
    logic strobe_level, capture;
    logic [7:0] mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [4:0] count, count_next;
    logic overflow, overflow_next, full, rd_data, rd_status, pop, push, push_req;
    logic [7:0] rd_mux;

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_strobe (
        .clk(clk),
        .reset(reset),
        .din(fpga_in[8]),
        .level(strobe_level),
        .capture(capture)
    );

    assign push_req = capture && strobe_level;
    assign full = count == DEPTH;
    assign rd_data = input_read_enable && input_data_address == ADDR_DATA;
    assign rd_status = input_read_enable && input_data_address == ADDR_STATUS;
    assign pop = rd_data && count != 5'd0;
    // a pop in the same cycle frees the slot the new byte needs
    assign push = push_req && (!full || pop);
    assign count_next = count + 5'(push) - 5'(pop);
    assign overflow_next = (push_req && full && !pop) || (overflow && !rd_status);

    always_comb begin
        rd_mux = input_data_address == ADDR_DATA     ? (count != 5'd0 ? mem[rd_ptr] : 8'h00) :
                 input_data_address == ADDR_STATUS   ? pack_status(overflow, full, count) :
                 input_data_address == ADDR_SWITCHES ? sw : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= sw;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta <= 8'h00;
            sw <= 8'h00;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= 5'd0;
            overflow <= 1'b0;
            press_pending <= 1'b0;
            input_data_out <= 8'h00;
            input_data_valid <= 1'b0;
        end else begin
            sw_meta <= fpga_in[7:0];
            sw <= sw_meta;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            count <= count_next;
            overflow <= overflow_next;
            press_pending <= count_next != 5'd0;
            input_data_out <= input_read_enable ? rd_mux : input_data_out;
            input_data_valid <= input_read_enable;
        end
    end

endmodule
